// File: rtl/exception_sequencer_pkg.sv
// Shared definitions for the exception sequencer: cause codes, state encoding
// and the exception vector base address.
package exception_sequencer_pkg;

   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_OPCODE   = 2'b01;
   localparam logic [1:0] CAUSE_OVERFLOW = 2'b10;
   localparam logic [1:0] CAUSE_DIV_ZERO = 2'b11;

   localparam logic [7:0] EXC_VECTOR_BASE = 8'd252;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SAVE_EPC = 3'd1,
      ST_MEM_READ = 3'd2,
      ST_MEM_WAIT = 3'd3,
      ST_LOAD_PC  = 3'd4,
      ST_DONE     = 3'd5
   } exc_state_e;

   // Vector bytes sit at the top of the byte space (253..255), so base+cause never wraps.
   function automatic logic [7:0] vector_addr(input logic [1:0] cause);
      if (cause == CAUSE_NONE) return 8'd0;
      return EXC_VECTOR_BASE + {6'd0, cause};
   endfunction

endpackage

// File: rtl/exception_sequencer_prio.sv
// Combinational priority encoder: opcode error beats divide-by-zero, which beats
// a qualified overflow.
module exc_priority_encoder
   import exception_sequencer_pkg::*;
(
   input  logic       opcode_error,
   input  logic       div_zero,
   input  logic       overflow,
   input  logic       allow_exception,
   output logic [1:0] cause
);

   always_comb begin
      cause = CAUSE_NONE;
      if (opcode_error)                    cause = CAUSE_OPCODE;
      else if (div_zero)                   cause = CAUSE_DIV_ZERO;
      else if (overflow && allow_exception) cause = CAUSE_OVERFLOW;
   end

endmodule

// File: rtl/exception_sequencer.sv
// Exception entry sequencer: saves PC-4 to EPC, fetches the handler address
// byte from the cause vector and loads it into PC while stalling the control unit.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   IDLE     | waiting for a qualified exception flag
//   SAVE_EPC | ALU computes PC-4, EPC loads it
//   MEM_READ | memory address forced to vector, read issued
//   MEM_WAIT | read held for the one-cycle memory latency
//   LOAD_PC  | PC loads the zero-extended vector byte
//   DONE     | one-cycle completion pulse, stall released
module exception_sequencer
   import exception_sequencer_pkg::*;
(
   input  logic       Clock,
   input  logic       Reset,
   input  logic       OPCode_Error,
   input  logic       Overflow,
   input  logic       AllowException,
   input  logic       Div_Zero,
   output logic       Exception_Signal,
   output logic       EPC_Write,
   output logic       ALU_PC_Minus4,
   output logic       Exc_Mem_Read,
   output logic [7:0] Exc_Vector_Addr,
   output logic       PC_Write_Exc,
   output logic       Exc_Done,
   output logic [1:0] Exc_Cause
);

   exc_state_e state_q, state_d;
   logic [1:0] cause_q, cause_d;
   logic [1:0] enc_cause;

   exc_priority_encoder u_prio (
      .opcode_error    (OPCode_Error),
      .div_zero        (Div_Zero),
      .overflow        (Overflow),
      .allow_exception (AllowException),
      .cause           (enc_cause)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
      end
   end

   // Flags are only looked at in IDLE; anything arriving mid-sequence is dropped.
   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      case (state_q)
         ST_IDLE: begin
            if (enc_cause != CAUSE_NONE) begin
               state_d = ST_SAVE_EPC;
               cause_d = enc_cause;
            end
         end
         ST_SAVE_EPC: state_d = ST_MEM_READ;
         ST_MEM_READ: state_d = ST_MEM_WAIT;
         ST_MEM_WAIT: state_d = ST_LOAD_PC;
         ST_LOAD_PC:  state_d = ST_DONE;
         ST_DONE:     state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      Exception_Signal = 1'b0;
      EPC_Write        = 1'b0;
      ALU_PC_Minus4    = 1'b0;
      Exc_Mem_Read     = 1'b0;
      PC_Write_Exc     = 1'b0;
      Exc_Done         = 1'b0;
      case (state_q)
         ST_SAVE_EPC: begin
            Exception_Signal = 1'b1;
            EPC_Write        = 1'b1;
            ALU_PC_Minus4    = 1'b1;
         end
         ST_MEM_READ, ST_MEM_WAIT: begin
            Exception_Signal = 1'b1;
            Exc_Mem_Read     = 1'b1;
         end
         ST_LOAD_PC: begin
            Exception_Signal = 1'b1;
            PC_Write_Exc     = 1'b1;
         end
         ST_DONE:  Exc_Done = 1'b1;
         default: ;
      endcase
   end

   assign Exc_Vector_Addr = vector_addr(cause_q);
   assign Exc_Cause       = cause_q;

endmodule

// File: tb/tb_exception_sequencer.sv
// Bench for exception_sequencer: directed scenarios plus random flag traffic,
// compared each cycle against a sequence-position reference model.
module tb_exception_sequencer;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       OPCode_Error, Overflow, AllowException, Div_Zero;
   logic       Exception_Signal, EPC_Write, ALU_PC_Minus4, Exc_Mem_Read;
   logic       PC_Write_Exc, Exc_Done;
   logic [7:0] Exc_Vector_Addr;
   logic [1:0] Exc_Cause;

   int checks = 0;
   int errors = 0;

   // Model: position within the 6-step exception sequence (0 = idle) and held cause.
   int m_pos   = 0;
   int m_cause = 0;
   int done_cnt;
   int pcw_cnt;

   exception_sequencer dut (
      .Clock            (Clock),
      .Reset            (Reset),
      .OPCode_Error     (OPCode_Error),
      .Overflow         (Overflow),
      .AllowException   (AllowException),
      .Div_Zero         (Div_Zero),
      .Exception_Signal (Exception_Signal),
      .EPC_Write        (EPC_Write),
      .ALU_PC_Minus4    (ALU_PC_Minus4),
      .Exc_Mem_Read     (Exc_Mem_Read),
      .Exc_Vector_Addr  (Exc_Vector_Addr),
      .PC_Write_Exc     (PC_Write_Exc),
      .Exc_Done         (Exc_Done),
      .Exc_Cause        (Exc_Cause)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int ref_cause(input logic op, input logic dz, input logic ov, input logic al);
      if (op) return 1;
      if (dz) return 3;
      if (ov && al) return 2;
      return 0;
   endfunction

   task automatic model_edge();
      int c;
      c = ref_cause(OPCode_Error, Div_Zero, Overflow, AllowException);
      if (Reset) begin
         m_pos = 0; m_cause = 0;
      end else if (m_pos == 0) begin
         if (c != 0) begin
            m_pos = 1; m_cause = c;
         end
      end else begin
         m_pos = (m_pos + 1) % 6;
      end
   endtask

   task automatic check_outputs();
      chk("exception_signal", int'(Exception_Signal), int'(m_pos >= 1 && m_pos <= 4));
      chk("epc_write",        int'(EPC_Write),        int'(m_pos == 1));
      chk("alu_pc_minus4",    int'(ALU_PC_Minus4),    int'(m_pos == 1));
      chk("exc_mem_read",     int'(Exc_Mem_Read),     int'(m_pos == 2 || m_pos == 3));
      chk("pc_write_exc",     int'(PC_Write_Exc),     int'(m_pos == 4));
      chk("exc_done",         int'(Exc_Done),         int'(m_pos == 5));
      chk("exc_cause",        int'(Exc_Cause),        m_cause);
      chk("exc_vector_addr",  int'(Exc_Vector_Addr),  (m_cause == 0) ? 0 : 252 + m_cause);
   endtask

   // Apply one set of inputs for one rising edge, advance the model, then check.
   task automatic step(input logic rst, input logic op, input logic dz,
                       input logic ov, input logic al);
      Reset = rst; OPCode_Error = op; Div_Zero = dz; Overflow = ov; AllowException = al;
      @(posedge Clock);
      model_edge();
      #1;
      check_outputs();
      if (Exc_Done)     done_cnt++;
      if (PC_Write_Exc) pcw_cnt++;
      @(negedge Clock);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      Reset = 1'b1; OPCode_Error = 1'b0; Div_Zero = 1'b0; Overflow = 1'b0; AllowException = 1'b0;
      @(negedge Clock);
      // Flags during reset must not be latched.
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 0, 0);
      idle(2);

      // Overflow without qualification is ignored, then the qualified one is taken.
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(7);

      // Single-cycle opcode error; completion latency counted explicitly too.
      done_cnt = 0; pcw_cnt = 0;
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(3);
      chk("opcode_pcw_at_n4", int'(PC_Write_Exc), 1);
      idle(1);
      chk("opcode_done_at_n5", int'(Exc_Done), 1);
      idle(1);
      chk("opcode_idle_at_n6", int'(Exception_Signal | Exc_Done), 0);
      chk("opcode_done_count", done_cnt, 1);

      // All flags together, then div-zero plus overflow.
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      idle(6);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      idle(6);

      // Div-zero pulsed during MEM_WAIT of an overflow sequence is dropped.
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(2);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(4);
      chk("ignored_cause", int'(Exc_Cause), 2);

      // Reset in MEM_READ aborts without a PC write.
      pcw_cnt = 0;
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(6);
      chk("abort_no_pc_write", pcw_cnt, 0);

      // Level-held flag gives back-to-back sequences every six cycles.
      done_cnt = 0;
      for (int i = 0; i < 18; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("held_flag_done_count", done_cnt, 3);
      idle(6);

      // Random traffic with occasional resets.
      for (int i = 0; i < 600; i++)
         step(($urandom_range(0, 39) == 0),
              ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 1)));
      idle(8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/exception_sequencer.md
EXCEPTION_SEQUENCER -- requirements
Module: exception_sequencer

Interface
REQ-001 Clock  input  1  system clock; all state changes on rising edge.
REQ-002 Reset  input  1  reset Reset, synchronous, active-high; clock Clock.
REQ-003 OPCode_Error  input  1  invalid opcode/funct flag from control unit, level.
REQ-004 Overflow  input  1  ALU signed overflow, level.
REQ-005 AllowException  input  1  qualifies Overflow; Overflow ignored when low.
REQ-006 Div_Zero  input  1  divide-by-zero flag from div unit, level.
REQ-007 Exception_Signal  output  1  high while sequence in progress; control unit stalls its FSM.
REQ-008 EPC_Write  output  1  load EPC from ALU result (PC-4).
REQ-009 ALU_PC_Minus4  output  1  forces ALU SrcA=PC, SrcB=4, op=SUB.
REQ-010 Exc_Mem_Read  output  1  forces memory address mux to Exc_Vector_Addr, read.
REQ-011 Exc_Vector_Addr  output  8  vector byte address, zero-extended to 32 bits by datapath.
REQ-012 PC_Write_Exc  output  1  load PC from zero-extended memory byte.
REQ-013 Exc_Done  output  1  one-cycle pulse, sequence complete.
REQ-014 Exc_Cause  output  2  latched cause code.

Function
REQ-015 Cause codes SHALL be: 00 none, 01 opcode, 10 overflow, 11 div-by-zero.
REQ-016 Priority SHALL be OPCode_Error > Div_Zero > (Overflow & AllowException).
REQ-017 FSM states SHALL be IDLE, SAVE_EPC, MEM_READ, MEM_WAIT, LOAD_PC, DONE; all outputs Moore (function of state and latched cause only).
REQ-018 IDLE: any qualified flag at rising edge -> SAVE_EPC, Exc_Cause latched from priority encoder same edge; no flag -> stay IDLE.
REQ-019 SAVE_EPC -> MEM_READ -> MEM_WAIT -> LOAD_PC -> DONE -> IDLE, unconditional, one cycle each.
REQ-020 Exception_Signal SHALL be 1 in SAVE_EPC..LOAD_PC, 0 in IDLE and DONE.
REQ-021 EPC_Write and ALU_PC_Minus4 SHALL be 1 only in SAVE_EPC.
REQ-022 Exc_Mem_Read SHALL be 1 in MEM_READ and MEM_WAIT (1-cycle memory latency).
REQ-023 PC_Write_Exc SHALL be 1 only in LOAD_PC; Exc_Done 1 only in DONE.
REQ-024 Exc_Vector_Addr SHALL equal 252 + Exc_Cause (8-bit, no wrap: 253/254/255); 0 when cause 00.
REQ-025 Latency: flag sampled at edge N -> EPC_Write cycle N+1, PC_Write_Exc cycle N+4, Exc_Done cycle N+5, IDLE at N+6.
REQ-026 Flags in any non-IDLE state SHALL be ignored, not queued; Exc_Cause unchanged.
REQ-027 Flags still high on return to IDLE SHALL start a new sequence (level-triggered); control unit must clear them during Exception_Signal.
REQ-028 Exc_Cause SHALL hold last cause until next accepted exception.

Reset
REQ-029 Reset SHALL have priority over all transitions, including mid-sequence: state IDLE, Exc_Cause 00.
REQ-030 Output values while/after Reset: all 1-bit outputs 0, Exc_Vector_Addr 0, Exc_Cause 00.
REQ-031 Flags present during a Reset cycle SHALL not be latched; detection resumes on first edge after Reset deasserts.

Structure
REQ-032 Shared package SHALL hold cause codes, state encoding, vector base constant 252.
REQ-033 One sub-module, exc_priority_encoder (combinational: three flags + AllowException -> 2-bit cause).
REQ-034 Single clock domain; no latches; state register 3 bits.

Verification
REQ-035 OPCode_Error=1 one cycle in IDLE -> Exc_Cause=01, EPC_Write at N+1, Exc_Vector_Addr=253 in MEM_READ/WAIT, PC_Write_Exc at N+4, Exc_Done at N+5.
REQ-036 Overflow=1, AllowException=0 -> stays IDLE, all outputs 0; repeat with AllowException=1 -> cause 10, vector 254.
REQ-037 OPCode_Error, Div_Zero, Overflow+AllowException all 1 same edge -> cause 01, vector 253; Div_Zero+Overflow -> cause 11, vector 255.
REQ-038 Div_Zero pulsed during MEM_WAIT of an overflow sequence -> ignored, cause stays 10, returns IDLE after DONE.
REQ-039 Reset asserted in MEM_READ -> next edge IDLE, outputs 0, Exc_Cause 00, no PC_Write_Exc.
REQ-040 Flag held high continuously -> back-to-back sequences, 6-cycle period, Exc_Done every sixth cycle.
